// File: rtl/fetch_queue_pkg.sv
// Shared type definitions for the instruction fetch path.
//   common : instruction bus request/response structs (64-bit address field;
//            narrower cores zero-extend into it).
//   pipes  : fetch queue entry ({pc, instr}) and fetch FSM state encoding.
package common;
  localparam int IBUS_AW = 64;

  typedef struct packed {
    logic               valid;
    logic [IBUS_AW-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

package pipes;
  localparam int FQ_PC_W = 64;

  typedef struct packed {
    logic [FQ_PC_W-1:0] pc;
    logic [31:0]        instr;
  } fetch_entry_t;

  // IDLE: nothing outstanding. WAIT: outstanding, result kept.
  // DROP: outstanding, result discarded (a redirect overtook it).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fq_state_t;
endpackage

// File: rtl/fetch_queue_ram.sv
// fq_ram: DEPTH-entry storage for fetch_entry_t.
// Ports: clk; we/waddr/wdata synchronous write port;
//        raddr/rdata asynchronous (combinational) read port.
// Entries are not reset: their contents are only observed when the
// owning queue's count says they are valid.
module fq_ram
  import pipes::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: issues sequential instruction fetches and buffers the results
// in a DEPTH-entry circular queue feeding decode.
// Ports:
//   clk, reset (async, active low)
//   ireq  : bus request {valid, addr}; iresp : bus response {data_ok, data}
//   redirect_valid / redirect_pc : flush the queue and restart fetch
//   out_valid / out_pc / out_instr / out_ready : head entry to decode
//   stall_hint : queue empty while a fetch is outstanding
//   dbg_state / dbg_count : FSM state and occupancy, for observation only
// Handshakes: the bus request holds valid and addr stable from issue until
// the cycle data_ok is seen (data_ok is only consumed while a request is
// outstanding, i.e. in WAIT or DROP). Decode takes the head entry in any
// cycle where out_valid && out_ready, unless a redirect flushes that cycle.
module fetch_queue
  import common::*;
  import pipes::*;
#(
  parameter int          XLEN     = 64,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  output ibus_req_t       ireq,
  input  ibus_resp_t      iresp,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  input  logic            out_ready,
  output logic            stall_hint,
  output fq_state_t       dbg_state,
  output logic [CW-1:0]   dbg_count
);

  localparam logic [XLEN-1:0] RST_PC = RESET_PC[XLEN-1:0];
  localparam logic [CW-1:0]   FULL   = CW'(DEPTH);

  fq_state_t       state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] redirect_target;
  logic [AW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d, cnt_after_pop;
  logic            push, pop, room, issue;
  fetch_entry_t    wr_entry, head_entry;

  assign redirect_target = redirect_pc & ~XLEN'(3);

  // Redirect outranks both queue operations.
  assign pop  = (count_q != '0) && out_ready && !redirect_valid;
  assign push = (state_q == WAIT) && iresp.data_ok && !redirect_valid;

  // Occupancy after this cycle's push/pop. Only WAIT can push, so in IDLE
  // and DROP this is simply the post-pop count; a pop in the same cycle is
  // what lets a full queue re-issue immediately.
  assign cnt_after_pop = count_q - CW'(pop);
  assign count_d       = cnt_after_pop + CW'(push);
  assign room          = count_d < FULL;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      // An in-flight fetch must still be drained; one completing right now
      // is simply discarded.
      state_d = (state_q != IDLE && !iresp.data_ok) ? DROP : IDLE;
    end else begin
      case (state_q)
        IDLE:       if (room) state_d = WAIT;
        WAIT, DROP: if (iresp.data_ok) state_d = room ? WAIT : IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    issue      = (state_q == IDLE) && !redirect_valid && room;
    ireq       = '0;
    // Gated by reset so the combinational IDLE issue stays quiet in reset.
    ireq.valid = reset && (issue || (state_q != IDLE));
    // In DROP the fetch_pc may already point at the redirect target, so
    // the outstanding address is kept in its own register.
    ireq.addr  = IBUS_AW'((state_q == IDLE) ? fetch_pc_q : req_addr_q);
  end

  assign out_valid  = (count_q != '0);
  assign stall_hint = (count_q == '0) && (state_q != IDLE);
  assign dbg_state  = state_q;
  assign dbg_count  = count_q;

  // ---------------- fetch address / pointers ----------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redirect_target;
    else if (push)      fetch_pc_d = fetch_pc_q + XLEN'(4);
  end

  // A new request is launched from IDLE or on the completion of the
  // previous one; otherwise the outstanding address is held.
  assign req_addr_d = (state_q == IDLE || iresp.data_ok) ? fetch_pc_d : req_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RST_PC;
      req_addr_q <= RST_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      if (redirect_valid) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + AW'(1);
        if (pop)  head_q <= head_q + AW'(1);
        count_q <= count_d;
      end
    end
  end

  // ---------------- storage ----------------
  assign wr_entry.pc    = FQ_PC_W'(req_addr_q);
  assign wr_entry.instr = iresp.data;

  fq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (head_entry)
  );

  assign out_pc    = head_entry.pc[XLEN-1:0];
  assign out_instr = head_entry.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed + random bench for fetch_queue: a default instance (XLEN=64,
// DEPTH=4) and a narrow instance (XLEN=32, DEPTH=2) for address wrap.
module tb_fetch_queue;
  import common::*;
  import pipes::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_w;

  // ---------------- default instance ----------------
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        stall_hint;
  fq_state_t   dbg_state;
  logic [2:0]  dbg_count;

  fetch_queue u_dut (
    .clk(clk), .reset(rst_n), .ireq(ireq), .iresp(iresp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .stall_hint(stall_hint),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // ---------------- narrow instance ----------------
  ibus_req_t   ireq_w;
  ibus_resp_t  iresp_w;
  logic        redirect_valid_w;
  logic [31:0] redirect_pc_w;
  logic        out_valid_w;
  logic [31:0] out_pc_w;
  logic [31:0] out_instr_w;
  logic        out_ready_w;
  logic        stall_hint_w;
  fq_state_t   dbg_state_w;
  logic [1:0]  dbg_count_w;

  fetch_queue #(.XLEN(32), .DEPTH(2)) u_dut_w (
    .clk(clk), .reset(rst_w), .ireq(ireq_w), .iresp(iresp_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
    .out_valid(out_valid_w), .out_pc(out_pc_w), .out_instr(out_instr_w),
    .out_ready(out_ready_w), .stall_hint(stall_hint_w),
    .dbg_state(dbg_state_w), .dbg_count(dbg_count_w)
  );

  // ---------------- scoreboard ----------------
  logic [95:0] exp_q[$];     // {pc, instr}, default instance
  logic [63:0] exp_w_q[$];   // {pc, instr}, narrow instance
  logic [63:0] mpc;          // model address of the next request
  logic [31:0] mpc_w;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic st(input fq_state_t s, input int c, input logic sh);
    chk("state", 64'(dbg_state), 64'(s));
    chk("count", 64'(dbg_count), 64'(c));
    chk("stall_hint", 64'(stall_hint), 64'(sh));
  endtask

  // One cycle on the default instance. rq: 0 no request check,
  // 1 expect ireq valid at rqa, 2 expect ireq not valid.
  task automatic cyc(input logic dok, input logic ordy, input logic redir,
                     input logic [63:0] rpc, input logic keep,
                     input int rq, input logic [63:0] rqa);
    logic [95:0] e;
    logic [31:0] d;
    d = instr_of(mpc);
    iresp.data_ok  = dok;
    iresp.data     = d;
    out_ready      = ordy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0 && ordy && !redir) begin
      e = exp_q.pop_front();
      chk("out_pc", out_pc, e[95:32]);
      chk("out_instr", 64'(out_instr), 64'(e[31:0]));
    end
    if (rq == 1) begin
      chk("req_valid", 64'(ireq.valid), 64'(1));
      chk("req_addr", ireq.addr, rqa);
    end else if (rq == 2) begin
      chk("req_idle", 64'(ireq.valid), 64'(0));
    end
    if (dok && keep && !redir) begin
      chk("resp_valid", 64'(ireq.valid), 64'(1));
      chk("resp_addr", ireq.addr, mpc);
      exp_q.push_back({mpc, d});
      mpc = mpc + 64'd4;
    end
    if (redir) begin
      exp_q.delete();
      mpc = rpc & ~64'h3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic dok, input logic ordy);
    cyc(dok, ordy, 1'b0, 64'h0, 1'b1, 0, 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] ew;
    logic        ok_w;
    logic        seen_wrap;
    int          pops_w;

    rst_n = 1'b0; rst_w = 1'b0;
    iresp = '0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    iresp_w = '0; out_ready_w = 1'b0; redirect_valid_w = 1'b0; redirect_pc_w = '0;
    mpc = 64'h8000_0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_req_valid", 64'(ireq.valid), 64'(0));
    st(IDLE, 0, 1'b0);
    rst_n = 1'b1;

    // Streaming: first issue from IDLE, then back-to-back with data_ok.
    cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1, 64'h8000_0000);
    st(WAIT, 0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 1, mpc);
    step(1'b0, 1'b1);
    st(WAIT, 0, 1'b1);

    // Fill with decode stalled, then release: issue in same cycle as pop.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    st(IDLE, 4, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 2, 64'h0);
    cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1, mpc);
    st(WAIT, 3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

    // Redirect together with data_ok and an available pop.
    step(1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 64'h8000_2000, 1'b0, 0, 64'h0);
    st(IDLE, 0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1, 64'h8000_2000);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // Redirect in first wait cycle of a slow fetch to 0x80000008.
    cyc(1'b1, 1'b1, 1'b1, 64'h8000_0008, 1'b0, 0, 64'h0);
    cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1, 64'h8000_0008);
    cyc(1'b0, 1'b1, 1'b1, 64'h8000_1002, 1'b0, 1, 64'h8000_0008);
    st(DROP, 0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1, 64'h8000_0008);
    cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1, 64'h8000_0008);
    st(WAIT, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 1, 64'h8000_1000);
    step(1'b0, 1'b1);

    // A second redirect while dropping only retargets fetch_pc.
    cyc(1'b0, 1'b1, 1'b1, 64'h8000_4000, 1'b0, 1, 64'h8000_1004);
    cyc(1'b0, 1'b1, 1'b1, 64'h8000_5004, 1'b0, 1, 64'h8000_1004);
    st(DROP, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1, 64'h8000_1004);
    cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 1, 64'h8000_5004);
    step(1'b0, 1'b1);

    // Asynchronous reset in WAIT with two entries queued.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    st(WAIT, 2, 1'b0);
    iresp.data_ok = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_req_valid", 64'(ireq.valid), 64'(0));
    chk("arst_stall", 64'(stall_hint), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    mpc = 64'h8000_0000;
    cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1, 64'h8000_0000);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // Narrow instance: wrap past the top of a 32-bit space, random decode.
    redirect_valid_w = 1'b1;
    redirect_pc_w    = 32'hFFFF_FFF0;
    rst_w = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid_w = 1'b0;
    mpc_w     = 32'hFFFF_FFF0;
    pops_w    = 0;
    seen_wrap = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ok_w = (dbg_state_w != IDLE) && ($urandom_range(0, 3) != 0);
      iresp_w.data_ok = ok_w;
      iresp_w.data    = instr_of(64'(mpc_w));
      out_ready_w     = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("w_out_valid", 64'(out_valid_w), 64'(exp_w_q.size() != 0));
      if (exp_w_q.size() != 0 && out_ready_w) begin
        ew = exp_w_q.pop_front();
        chk("w_out_pc", 64'(out_pc_w), 64'(ew[63:32]));
        chk("w_out_instr", 64'(out_instr_w), 64'(ew[31:0]));
        if (ew[63:32] == 32'h0) seen_wrap = 1'b1;
        pops_w++;
      end
      if (ok_w) begin
        chk("w_req_addr", ireq_w.addr, 64'(mpc_w));
        exp_w_q.push_back({mpc_w, instr_of(64'(mpc_w))});
        mpc_w = mpc_w + 32'd4;
      end
      @(posedge clk);
      #1;
    end
    chk("w_pops_enough", 64'(pops_w > 100), 64'(1));
    chk("w_wrap_seen", 64'(seen_wrap), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
